// File: rtl/conv_pkg.sv
// Shared definitions for the convolution datapath: image/kernel geometry,
// result and address widths, and the feature-map writer state encoding.
package conv_pkg;

    localparam int IMG_W  = 28;
    localparam int IMG_H  = 28;
    localparam int KSIZE  = 3;
    localparam int OUT_W  = IMG_W - KSIZE + 1;
    localparam int OUT_H  = IMG_H - KSIZE + 1;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 10;
    localparam int ROW_W  = 5;
    localparam int COL_W  = 5;

    // Most negative signed result; the running maximum starts here.
    localparam logic [DATA_W-1:0] DATA_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        CAPTURE = 1'b1
    } state_t;

    // Signed greater-than on raw result vectors.
    function automatic logic signed_gt(input logic [DATA_W-1:0] a,
                                       input logic [DATA_W-1:0] b);
        return ($signed(a) > $signed(b));
    endfunction

endpackage

// File: rtl/conv_fmap_addr_gen.sv
// Raster walk over the 26x26 feature map. row/col track the 2-D position so
// the final pixel can be recognised; addr is a separate running counter so
// the RAM address never needs a row*OUT_W multiply.
module conv_fmap_addr_gen
    import conv_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              inc,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    logic [ROW_W-1:0]  row_r;
    logic [COL_W-1:0]  col_r;
    logic [ADDR_W-1:0] addr_r;
    logic              col_last_s;

    assign col_last_s = (col_r == COL_W'(OUT_W - 1));
    assign last       = col_last_s && (row_r == ROW_W'(OUT_H - 1));
    assign addr       = addr_r;

    // Position counters: clear on frame start, advance once per written pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_r  <= {ROW_W{1'b0}};
            col_r  <= {COL_W{1'b0}};
            addr_r <= {ADDR_W{1'b0}};
        end else if (clr) begin
            row_r  <= {ROW_W{1'b0}};
            col_r  <= {COL_W{1'b0}};
            addr_r <= {ADDR_W{1'b0}};
        end else if (inc) begin
            if (col_last_s) begin
                col_r <= {COL_W{1'b0}};
                row_r <= row_r + ROW_W'(1);
            end else begin
                col_r <= col_r + COL_W'(1);
                row_r <= row_r;
            end
            addr_r <= addr_r + ADDR_W'(1);
        end else begin
            row_r  <= row_r;
            col_r  <= col_r;
            addr_r <= addr_r;
        end
    end

endmodule

// File: rtl/conv_fmap_writer.sv
// Sink of the convolution result stream. Captures one 26x26 frame into the
// feature-map RAM in raster order, pulses frame_done with the final write and
// reports the signed frame maximum. All outputs come straight from flops.
module conv_fmap_writer
    import conv_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              frame_done,
    output logic [DATA_W-1:0] max_val,
    output logic              drop_err
);

    state_t            state_r;
    state_t            next_state_s;
    logic              accept_s;
    logic              write_s;
    logic              clr_s;
    logic              last_s;
    logic [ADDR_W-1:0] addr_s;

    logic              in_ready_r;
    logic              wr_en_r;
    logic [ADDR_W-1:0] wr_addr_r;
    logic [DATA_W-1:0] wr_data_r;
    logic              busy_r;
    logic              frame_done_r;
    logic [DATA_W-1:0] max_val_r;
    logic              drop_err_r;

    // in_ready is a flop that only rises in CAPTURE, so an accept implies CAPTURE.
    assign accept_s = in_valid & in_ready_r;
    // An abort in the same cycle as an accept cancels that pixel.
    assign write_s  = accept_s & ~abort;
    assign clr_s    = (state_r == IDLE) & start;

    conv_fmap_addr_gen u_addr_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr_s),
        .inc  (write_s),
        .addr (addr_s),
        .last (last_s)
    );

    // Next-state logic: arm on start, leave on abort or after the final pixel.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    next_state_s = CAPTURE;
                end else begin
                    next_state_s = IDLE;
                end
            end
            CAPTURE: begin
                if (abort) begin
                    next_state_s = IDLE;
                end else if (accept_s && last_s) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = CAPTURE;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State register plus the flow-control flags that mirror it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= next_state_s;
            in_ready_r <= (next_state_s == CAPTURE);
            busy_r     <= (next_state_s == CAPTURE);
        end
    end

    // RAM write port: one-cycle latency; address/data hold when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en_r      <= 1'b0;
            wr_addr_r    <= {ADDR_W{1'b0}};
            wr_data_r    <= {DATA_W{1'b0}};
            frame_done_r <= 1'b0;
        end else if (write_s) begin
            wr_en_r      <= 1'b1;
            wr_addr_r    <= addr_s;
            wr_data_r    <= in_data;
            frame_done_r <= last_s;
        end else begin
            wr_en_r      <= 1'b0;
            wr_addr_r    <= wr_addr_r;
            wr_data_r    <= wr_data_r;
            frame_done_r <= 1'b0;
        end
    end

    // Frame maximum: restarted on frame start, updated by each written pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_val_r <= DATA_MIN;
        end else if (clr_s) begin
            max_val_r <= DATA_MIN;
        end else if (write_s && signed_gt(in_data, max_val_r)) begin
            max_val_r <= in_data;
        end else begin
            max_val_r <= max_val_r;
        end
    end

    // Sticky flag for results offered while no frame is being captured.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_err_r <= 1'b0;
        end else if (clr_s) begin
            drop_err_r <= 1'b0;
        end else if (in_valid && (state_r != CAPTURE)) begin
            drop_err_r <= 1'b1;
        end else begin
            drop_err_r <= drop_err_r;
        end
    end

    assign in_ready   = in_ready_r;
    assign wr_en      = wr_en_r;
    assign wr_addr    = wr_addr_r;
    assign wr_data    = wr_data_r;
    assign busy       = busy_r;
    assign frame_done = frame_done_r;
    assign max_val    = max_val_r;
    assign drop_err   = drop_err_r;

endmodule

// File: tb/tb_conv_fmap_writer.sv
// Scoreboard bench for conv_fmap_writer: the driver queues each expected RAM
// write when it offers a pixel; a negedge monitor pops and compares writes.
module tb_conv_fmap_writer;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic        wr_en;
    logic [9:0]  wr_addr;
    logic [15:0] wr_data;
    logic        busy;
    logic        frame_done;
    logic [15:0] max_val;
    logic        drop_err;

    typedef struct packed {
        logic [9:0]  addr;
        logic [15:0] data;
        logic        last;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   checks   = 0;
    int   errors   = 0;
    int   done_cnt = 0;

    conv_fmap_writer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .frame_done (frame_done),
        .max_val    (max_val),
        .drop_err   (drop_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_in_ready"},   {31'd0, in_ready},   32'd0);
        chk({tag, "_wr_en"},      {31'd0, wr_en},      32'd0);
        chk({tag, "_wr_addr"},    {22'd0, wr_addr},    32'd0);
        chk({tag, "_wr_data"},    {16'd0, wr_data},    32'd0);
        chk({tag, "_busy"},       {31'd0, busy},       32'd0);
        chk({tag, "_frame_done"}, {31'd0, frame_done}, 32'd0);
        chk({tag, "_max_val"},    {16'd0, max_val},    32'h0000_8000);
        chk({tag, "_drop_err"},   {31'd0, drop_err},   32'd0);
    endtask

    // Monitor: every write must match the head of the expectation queue, and
    // frame_done may only accompany the write flagged as the frame's last.
    always @(negedge clk) begin
        if (!rst) begin
            if (frame_done) done_cnt++;
            if (wr_en) begin
                if (q.size() == 0) begin
                    chk("unexpected_write", {31'd0, wr_en}, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("wr_addr", {22'd0, wr_addr}, {22'd0, e.addr});
                    chk("wr_data", {16'd0, wr_data}, {16'd0, e.data});
                    chk("frame_done_on_write", {31'd0, frame_done}, {31'd0, e.last});
                end
            end else begin
                chk("frame_done_without_write", {31'd0, frame_done}, 32'd0);
            end
        end
    end

    // One frame attempt. neg: data=-500-i else i; gap: in_valid low every third
    // cycle; abort_at/rst_at: pixel index at which to abort / pulse reset (-1 none).
    task automatic run_frame(input int neg, input int gap, input int abort_at,
                             input int rst_at, input logic [15:0] exp_max);
        int i;
        int cyc;
        int v;
        int stop;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_busy",     {31'd0, busy},     32'd1);
        chk("start_in_ready", {31'd0, in_ready}, 32'd1);
        chk("start_drop_err", {31'd0, drop_err}, 32'd0);
        i = 0;
        cyc = 0;
        stop = 0;
        while (i < 676 && stop == 0) begin
            if (gap != 0 && (cyc % 3) == 2) begin
                in_valid = 1'b0;
                step();
                cyc++;
            end else if (i == rst_at) begin
                in_valid = 1'b0;
                rst = 1'b1;
                #1;
                q.delete();
                check_reset_vals("midframe_rst");
                step();
                rst = 1'b0;
                stop = 1;
            end else begin
                v = (neg != 0) ? (-500 - i) : i;
                in_data  = v[15:0];
                in_valid = 1'b1;
                abort    = (i == abort_at);
                if (i != abort_at) q.push_back({i[9:0], v[15:0], (i == 675)});
                step();
                cyc++;
                if (i == abort_at) begin
                    abort    = 1'b0;
                    in_valid = 1'b0;
                    chk("abort_busy",     {31'd0, busy},     32'd0);
                    chk("abort_in_ready", {31'd0, in_ready}, 32'd0);
                    stop = 1;
                end
                i++;
            end
        end
        in_valid = 1'b0;
        if (stop == 0) begin
            chk("frame_max_val",  {16'd0, max_val},  {16'd0, exp_max});
            chk("frame_in_ready", {31'd0, in_ready}, 32'd0);
            chk("frame_busy",     {31'd0, busy},     32'd0);
        end
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        in_valid = 1'b0;
        in_data  = 16'd0;
        #3;
        check_reset_vals("por");
        step();
        step();
        rst = 1'b0;
        step();

        // Full-rate ascending frame.
        run_frame(0, 0, -1, -1, 16'd675);
        // Re-arm in the cycle after frame_done, stream with bubbles.
        step();
        run_frame(0, 1, -1, -1, 16'd675);
        step();
        // All-negative frame: max is the first pixel.
        run_frame(1, 0, -1, -1, 16'hFE0C);
        step();
        // Abort with pixel 100, then a fresh frame from address 0.
        run_frame(0, 0, 100, -1, 16'd0);
        step();
        run_frame(0, 0, -1, -1, 16'd675);
        step();
        // Data offered while idle.
        in_valid = 1'b1;
        in_data  = 16'h1234;
        step();
        in_valid = 1'b0;
        chk("idle_drop_err", {31'd0, drop_err}, 32'd1);
        chk("idle_wr_en",    {31'd0, wr_en},    32'd0);
        step();
        run_frame(0, 0, 5, -1, 16'd0);
        step();
        // Reset pulse at pixel 300, then a fresh frame.
        run_frame(0, 0, -1, 300, 16'd0);
        step();
        run_frame(0, 0, -1, -1, 16'd675);
        step();
        step();
        step();

        chk("frame_done_count", done_cnt, 32'd5);
        chk("queue_drained",    q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Guard against a stuck run.
    initial begin
        #2000000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
